gray_step_sequencer: RTL

Sequencer that walks a WIDTH-bit binary position through a programmed number of up or down steps and presents both the binary value and its Gray encoding as registered outputs. It drives Gray-coded position and select buses, so that exactly one output bit toggles per step. A host starts a run with a start pulse, can pause or abort it, and receives a one-cycle done pulse when the run completes.

---
 rtl/gray_step_sequencer_pkg.sv | 13 +
 rtl/gray_step_sequencer_if.sv | 32 +++
 rtl/gray_step_sequencer_gray_encode.sv | 11 +
 rtl/gray_step_sequencer.sv | 97 +++++++++
 4 files changed

// File: rtl/gray_step_sequencer_pkg.sv
// rtl/gray_step_sequencer_pkg.sv - shared state encoding and default widths for the gray step sequencer
package gray_step_sequencer_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gray_step_sequencer_if.sv
// rtl/gray_step_sequencer_if.sv - host control and position bus of the gray step sequencer
interface gray_step_sequencer_if
  import gray_step_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic [WIDTH-1:0] start_val;
  logic [CNT_W-1:0] num_steps;
  logic             dir;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             step_valid;
  logic             busy;
  logic             done;

  // master is the host issuing runs; slave is the sequencer
  modport master (
    output start, start_val, num_steps, dir, pause, abort,
    input  bin_out, gray_out, step_valid, busy, done
  );

  modport slave (
    input  start, start_val, num_steps, dir, pause, abort,
    output bin_out, gray_out, step_valid, busy, done
  );

endinterface

// File: rtl/gray_step_sequencer_gray_encode.sv
// rtl/gray_step_sequencer_gray_encode.sv - combinational binary to Gray converter
module gray_encode #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_step_sequencer.sv
// rtl/gray_step_sequencer.sv - steps a binary position up or down and registers it with its Gray code
module gray_step_sequencer
  import gray_step_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_step_sequencer_if.slave bus
);

  state_t           state, state_n;
  logic [WIDTH-1:0] bin_q, bin_n;
  logic [WIDTH-1:0] gray_q, gray_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic             dir_q, dir_n;
  logic             step_q, step_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  always_comb begin
    state_n = state;
    bin_n   = bin_q;
    rem_n   = rem_q;
    dir_n   = dir_q;
    step_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          bin_n   = bus.start_val;
          rem_n   = bus.num_steps;
          dir_n   = bus.dir;
          state_n = (bus.num_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // abort wins over pause and leaves the position where it is
        if (bus.abort) begin
          state_n = IDLE;
        end else if (!bus.pause) begin
          bin_n  = dir_q ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
          rem_n  = rem_q - CNT_W'(1);
          step_n = 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

  // Gray is derived from the next binary value so both register on the same edge
  gray_encode #(
    .WIDTH(WIDTH)
  ) u_gray_encode (
    .bin  (bin_n),
    .gray (gray_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bin_q  <= '0;
      gray_q <= '0;
      rem_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      bin_q  <= bin_n;
      gray_q <= gray_n;
      rem_q  <= rem_n;
      dir_q  <= dir_n;
      step_q <= step_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign bus.bin_out    = bin_q;
  assign bus.gray_out   = gray_q;
  assign bus.step_valid = step_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
